// File: rtl/ascon_pack.sv
// Shared ASCON types and constants for the inverse diffusion layer.
package ascon_pack;

  localparam int unsigned PL_ROWS     = 5;
  localparam int unsigned PL_WORD_W   = 64;
  localparam int unsigned PL_ROT_W    = 6;
  localparam int unsigned PL_CNT_W    = 3;
  localparam int unsigned PL_INV_ITER = 6;

  // Five 64-bit state rows, row i at index i.
  typedef logic [PL_ROWS-1:0][PL_WORD_W-1:0] type_state;

  // Right-rotation amounts of the forward diffusion layer, per row.
  localparam logic [PL_ROT_W-1:0] PL_ROT_A [PL_ROWS] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [PL_ROT_W-1:0] PL_ROT_B [PL_ROWS] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } type_pl_inv_fsm;

  // Rotate a 64-bit word right by n (n = 0 leaves it unchanged).
  function automatic logic [PL_WORD_W-1:0] ror64(input logic [PL_WORD_W-1:0] x,
                                                 input logic [PL_ROT_W-1:0]  n);
    logic [2*PL_WORD_W-1:0] d;
    d = {x, x} >> n;
    return d[PL_WORD_W-1:0];
  endfunction

endpackage

// File: rtl/pl_inv_iter_pl_step.sv
// One factor Sigma^(2^k) of the inverse diffusion layer, applied to every row.
module pl_step
  import ascon_pack::*;
(
  input  type_state           cur,
  input  logic [PL_CNT_W-1:0] k,
  output type_state           nxt
);

  // Rotation amounts scale by 2^k; keeping only the low 6 bits gives mod 64.
  always_comb begin
    nxt = '0;
    for (int unsigned i = 0; i < PL_ROWS; i++) begin
      nxt[i] = cur[i]
             ^ ror64(cur[i], PL_ROT_W'(PL_ROT_A[i] << k))
             ^ ror64(cur[i], PL_ROT_W'(PL_ROT_B[i] << k));
    end
  end

endmodule

// File: rtl/pl_inv_iter.sv
// Iterative inverse of the ASCON linear layer: six Sigma^(2^k) steps over one register.
module pl_inv_iter
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  type_state pl_inv_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output type_state pl_inv_o
);

  localparam logic [PL_CNT_W-1:0] CNT_LAST = PL_CNT_W'(PL_INV_ITER - 1);

  type_pl_inv_fsm      fsm, fsm_nxt;
  logic [PL_CNT_W-1:0] cnt, cnt_nxt;
  type_state           st, st_nxt, step_s;

  pl_step u_step (
    .cur (st),
    .k   (cnt),
    .nxt (step_s)
  );

  // State, counter, datapath register and decoded handshake flops.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm         <= IDLE;
      cnt         <= '0;
      st          <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
    end else begin
      fsm         <= fsm_nxt;
      cnt         <= cnt_nxt;
      st          <= st_nxt;
      in_ready_o  <= (fsm_nxt == IDLE);
      out_valid_o <= (fsm_nxt == DONE);
    end
  end

  // Next-state logic: load on accept, one step per RUN cycle, hold in DONE.
  always_comb begin
    fsm_nxt = fsm;
    cnt_nxt = cnt;
    st_nxt  = st;
    case (fsm)
      IDLE: begin
        if (in_valid_i) begin
          st_nxt  = pl_inv_i;
          cnt_nxt = '0;
          fsm_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt > CNT_LAST) begin
          cnt_nxt = '0;
          fsm_nxt = IDLE;
        end else begin
          st_nxt  = step_s;
          cnt_nxt = cnt + PL_CNT_W'(1);
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            fsm_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          fsm_nxt = IDLE;
        end
      end
      default: begin
        fsm_nxt = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  assign pl_inv_o = st;

endmodule
